// File: rtl/alu_issue_queue_pkg.sv
// Shared constants, entry layout and CDB match helper for the ALU issue queue.
package alu_issue_queue_pkg;

  localparam int CORE_XLEN    = 32;
  localparam int LOG2_PREGS   = 6;
  localparam int CORE_ROB_W   = 6;
  localparam int ALU_RS_DEPTH = 8;

  // One reservation-station slot. rdyN=1 means valN holds the final operand.
  typedef struct packed {
    logic                  valid;
    logic [7:0]            op;
    logic [LOG2_PREGS-1:0] dst;
    logic [CORE_ROB_W-1:0] rob;
    logic [LOG2_PREGS-1:0] tag1;
    logic                  rdy1;
    logic [CORE_XLEN-1:0]  val1;
    logic [LOG2_PREGS-1:0] tag2;
    logic                  rdy2;
    logic [CORE_XLEN-1:0]  val2;
  } alu_rs_entry_t;

  // A still-waiting source is woken when the CDB carries its full tag.
  function automatic logic tag_hit(input logic                  cdb_valid,
                                   input logic [LOG2_PREGS-1:0] cdb_tag,
                                   input logic [LOG2_PREGS-1:0] src_tag,
                                   input logic                  src_rdy);
    return cdb_valid & ~src_rdy & (cdb_tag == src_tag);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB and issue signal bundle of the ALU issue queue.
interface alu_issue_queue_if
  import alu_issue_queue_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int PHYS_W = LOG2_PREGS,
  parameter int ROB_W  = CORE_ROB_W,
  parameter int DEPTH  = ALU_RS_DEPTH
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              disp_valid;
  logic              disp_ready;
  logic [7:0]        disp_op;
  logic [PHYS_W-1:0] disp_dst_tag;
  logic [ROB_W-1:0]  disp_rob_tag;
  logic [PHYS_W-1:0] disp_src1_tag;
  logic [PHYS_W-1:0] disp_src2_tag;
  logic              disp_src1_rdy;
  logic              disp_src2_rdy;
  logic [XLEN-1:0]   disp_src1_val;
  logic [XLEN-1:0]   disp_src2_val;

  logic              cdb_valid;
  logic [PHYS_W-1:0] cdb_tag;
  logic [XLEN-1:0]   cdb_value;

  logic              alu_ready;
  logic              issue_valid;
  logic [7:0]        issue_op;
  logic [PHYS_W-1:0] issue_dst_tag;
  logic [ROB_W-1:0]  issue_rob_tag;
  logic [XLEN-1:0]   issue_src1_val;
  logic [XLEN-1:0]   issue_src2_val;

  logic [OCC_W-1:0]  occupancy;

  // Pipeline side: dispatch, CDB and ALU.
  modport master (
    output disp_valid, disp_op, disp_dst_tag, disp_rob_tag,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_val, disp_src2_val,
           cdb_valid, cdb_tag, cdb_value, alu_ready,
    input  disp_ready, issue_valid, issue_op, issue_dst_tag, issue_rob_tag,
           issue_src1_val, issue_src2_val, occupancy
  );

  // The queue itself.
  modport slave (
    input  disp_valid, disp_op, disp_dst_tag, disp_rob_tag,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_val, disp_src2_val,
           cdb_valid, cdb_tag, cdb_value, alu_ready,
    output disp_ready, issue_valid, issue_op, issue_dst_tag, issue_rob_tag,
           issue_src1_val, issue_src2_val, occupancy
  );

endinterface

// File: rtl/alu_issue_queue_select.sv
// Priority encoder: finds the lowest-index (oldest) ready slot.
module alu_rs_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the youngest down so the oldest request wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting reservation station for the integer ALU. Slot 0 is the oldest.
// Each edge: the issued slot is removed and younger slots shift down, then
// the dispatched op is appended at the first free slot behind them.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int PHYS_W = LOG2_PREGS,
  parameter int ROB_W  = CORE_ROB_W,
  parameter int DEPTH  = ALU_RS_DEPTH
) (
  input logic         clk,
  input logic         reset,
  input logic         flush,
  alu_issue_queue_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  alu_rs_entry_t [DEPTH-1:0] q_reg;
  alu_rs_entry_t [DEPTH-1:0] woken;
  alu_rs_entry_t [DEPTH-1:0] shifted;
  alu_rs_entry_t [DEPTH-1:0] q_next;
  alu_rs_entry_t             disp_raw;
  alu_rs_entry_t             disp_entry;

  logic [DEPTH-1:0] ready_vec;
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_after;
  logic [OCC_W-1:0] occ_next;
  logic             issue_load;
  logic             do_issue;
  logic             do_disp;

  logic              issue_valid_reg;
  logic [7:0]        issue_op_reg;
  logic [PHYS_W-1:0] issue_dst_reg;
  logic [ROB_W-1:0]  issue_rob_reg;
  logic [XLEN-1:0]   issue_src1_reg;
  logic [XLEN-1:0]   issue_src2_reg;

  // Applies a CDB broadcast to whichever sources of a valid entry still wait.
  function automatic alu_rs_entry_t wake(input alu_rs_entry_t     e,
                                         input logic              cv,
                                         input logic [PHYS_W-1:0] ct,
                                         input logic [XLEN-1:0]   cval);
    alu_rs_entry_t w;
    w = e;
    if (e.valid && tag_hit(cv, ct, e.tag1, e.rdy1)) begin
      w.rdy1 = 1'b1;
      w.val1 = cval;
    end
    if (e.valid && tag_hit(cv, ct, e.tag2, e.rdy2)) begin
      w.rdy2 = 1'b1;
      w.val2 = cval;
    end
    return w;
  endfunction

  // Capacity is judged on the registered count only; a same-cycle issue
  // does not open a slot for dispatch.
  assign bus.disp_ready = (occ_reg < OCC_W'(DEPTH));
  assign do_disp        = bus.disp_valid & bus.disp_ready;
  assign issue_load     = ~issue_valid_reg | bus.alu_ready;
  assign do_issue       = issue_load & found;
  assign occ_after      = occ_reg - OCC_W'(do_issue);
  assign occ_next       = occ_after + OCC_W'(do_disp);

  // Dispatch fields packed into an entry before same-cycle CDB capture.
  always_comb begin
    disp_raw       = '0;
    disp_raw.valid = 1'b1;
    disp_raw.op    = bus.disp_op;
    disp_raw.dst   = bus.disp_dst_tag;
    disp_raw.rob   = bus.disp_rob_tag;
    disp_raw.tag1  = bus.disp_src1_tag;
    disp_raw.rdy1  = bus.disp_src1_rdy;
    disp_raw.val1  = bus.disp_src1_val;
    disp_raw.tag2  = bus.disp_src2_tag;
    disp_raw.rdy2  = bus.disp_src2_rdy;
    disp_raw.val2  = bus.disp_src2_val;
  end

  assign disp_entry = wake(disp_raw, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

  // Per-slot readiness, wakeup, compaction and append.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Select sees registered state only, so a wakeup this edge is eligible next cycle.
      assign ready_vec[gi] = q_reg[gi].valid & q_reg[gi].rdy1 & q_reg[gi].rdy2;
      assign woken[gi]     = wake(q_reg[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

      if (gi == DEPTH - 1) begin : g_top
        assign shifted[gi] = (do_issue && (sel_idx <= IDX_W'(gi))) ? '0 : woken[gi];
      end else begin : g_mid
        assign shifted[gi] = (do_issue && (sel_idx <= IDX_W'(gi))) ? woken[gi+1] : woken[gi];
      end

      assign q_next[gi] = (do_disp && (occ_after == OCC_W'(gi))) ? disp_entry : shifted[gi];
    end
  endgenerate

  alu_rs_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req   (ready_vec),
    .found (found),
    .idx   (sel_idx)
  );

  // Queue, count and issue register; flush wins over issue and dispatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg           <= '0;
      occ_reg         <= '0;
      issue_valid_reg <= 1'b0;
      issue_op_reg    <= '0;
      issue_dst_reg   <= '0;
      issue_rob_reg   <= '0;
      issue_src1_reg  <= '0;
      issue_src2_reg  <= '0;
    end else if (flush) begin
      q_reg           <= '0;
      occ_reg         <= '0;
      issue_valid_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      occ_reg <= occ_next;
      if (issue_load) begin
        issue_valid_reg <= found;
        if (found) begin
          issue_op_reg   <= q_reg[sel_idx].op;
          issue_dst_reg  <= q_reg[sel_idx].dst;
          issue_rob_reg  <= q_reg[sel_idx].rob;
          issue_src1_reg <= q_reg[sel_idx].val1;
          issue_src2_reg <= q_reg[sel_idx].val2;
        end
      end
    end
  end

  assign bus.issue_valid    = issue_valid_reg;
  assign bus.issue_op       = issue_op_reg;
  assign bus.issue_dst_tag  = issue_dst_reg;
  assign bus.issue_rob_tag  = issue_rob_reg;
  assign bus.issue_src1_val = issue_src1_reg;
  assign bus.issue_src2_val = issue_src2_reg;
  assign bus.occupancy      = occ_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = ALU_RS_DEPTH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_issue_queue_if bus ();

  alu_issue_queue dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age-ordered list of waiting ops plus the issue slot.
  typedef struct {
    logic [7:0]  op;
    logic [5:0]  dst;
    logic [5:0]  rob;
    logic [5:0]  t1;
    logic [5:0]  t2;
    bit          r1;
    bit          r2;
    logic [31:0] v1;
    logic [31:0] v2;
  } ment_t;

  ment_t mq[$];
  bit    m_iv = 1'b0;
  ment_t m_is;

  task automatic model_step();
    ment_t e;
    int    pick;
    bit    room;
    pick = -1;
    if (flush) begin
      mq.delete();
      m_iv = 1'b0;
      return;
    end
    room = (mq.size() < DEPTH);
    if (!m_iv || bus.alu_ready) begin
      foreach (mq[i]) if (pick < 0 && mq[i].r1 && mq[i].r2) pick = i;
      if (pick >= 0) begin
        m_is = mq[pick];
        m_iv = 1'b1;
        mq.delete(pick);
        $display("issue rob=%0d op=%02h dst=%0d src1=%08h src2=%08h",
                 m_is.rob, m_is.op, m_is.dst, m_is.v1, m_is.v2);
      end else begin
        m_iv = 1'b0;
      end
    end
    foreach (mq[i]) begin
      if (bus.cdb_valid && !mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin
        mq[i].r1 = 1'b1;
        mq[i].v1 = bus.cdb_value;
      end
      if (bus.cdb_valid && !mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin
        mq[i].r2 = 1'b1;
        mq[i].v2 = bus.cdb_value;
      end
    end
    if (bus.disp_valid && room) begin
      e.op  = bus.disp_op;
      e.dst = bus.disp_dst_tag;
      e.rob = bus.disp_rob_tag;
      e.t1  = bus.disp_src1_tag;
      e.t2  = bus.disp_src2_tag;
      e.r1  = bus.disp_src1_rdy;
      e.r2  = bus.disp_src2_rdy;
      e.v1  = bus.disp_src1_val;
      e.v2  = bus.disp_src2_val;
      if (bus.cdb_valid && !e.r1 && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.v1 = bus.cdb_value; end
      if (bus.cdb_valid && !e.r2 && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.v2 = bus.cdb_value; end
      mq.push_back(e);
    end
  endtask

  // Compare process: advance the model at each edge, check DUT just after.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_iv = 1'b0;
    end else begin
      model_step();
    end
    #1;
    if (!reset) begin
      chk("disp_ready", bus.disp_ready, (mq.size() < DEPTH));
      chk("occupancy", bus.occupancy, mq.size());
      chk("issue_valid", bus.issue_valid, m_iv);
      if (m_iv) begin
        chk("issue_op", bus.issue_op, m_is.op);
        chk("issue_dst", bus.issue_dst_tag, m_is.dst);
        chk("issue_rob", bus.issue_rob_tag, m_is.rob);
        chk("issue_src1", bus.issue_src1_val, m_is.v1);
        chk("issue_src2", bus.issue_src2_val, m_is.v2);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input logic ar);
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.alu_ready  = ar;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [7:0] op, input logic [5:0] dst, input logic [5:0] rob,
                      input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                      input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    bus.disp_valid    = 1'b1;
    bus.disp_op       = op;
    bus.disp_dst_tag  = dst;
    bus.disp_rob_tag  = rob;
    bus.disp_src1_tag = t1;
    bus.disp_src1_rdy = r1;
    bus.disp_src1_val = v1;
    bus.disp_src2_tag = t2;
    bus.disp_src2_rdy = r2;
    bus.disp_src2_val = v2;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  initial begin
    idle(1'b1);
    disp(8'h0, 6'd0, 6'd0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
    bus.disp_valid = 1'b0;
    cdb(6'd0, 32'h0);
    bus.cdb_valid = 1'b0;
    tick();
    tick();
    chk("reset_occupancy", bus.occupancy, 0);
    chk("reset_issue_valid", bus.issue_valid, 0);
    chk("reset_disp_ready", bus.disp_ready, 1);
    chk("reset_issue_src1", bus.issue_src1_val, 0);
    chk("reset_issue_rob", bus.issue_rob_tag, 0);
    reset = 1'b0;
    tick();

    // Single fully-ready op: in queue at t1, issued at t2.
    disp(8'h80, 6'd33, 6'd5, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    tick();
    chk("t1_occupancy", bus.occupancy, 1);
    chk("t1_issue_valid", bus.issue_valid, 0);
    idle(1'b1);
    tick();
    chk("t2_issue_valid", bus.issue_valid, 1);
    chk("t2_src1", bus.issue_src1_val, 5);
    chk("t2_src2", bus.issue_src2_val, 7);
    chk("t2_dst", bus.issue_dst_tag, 33);
    chk("t2_rob", bus.issue_rob_tag, 5);
    chk("t2_op", bus.issue_op, 8'h80);
    chk("t2_occupancy", bus.occupancy, 0);
    tick();
    tick();

    // Younger ready op bypasses an older waiting one.
    disp(8'h01, 6'd40, 6'd1, 6'd12, 1'b0, 32'h0, 6'd3, 1'b1, 32'd2);
    tick();
    disp(8'h02, 6'd41, 6'd2, 6'd4, 1'b1, 32'd3, 6'd5, 1'b1, 32'd4);
    tick();
    idle(1'b1);
    tick();
    chk("bypass_b_valid", bus.issue_valid, 1);
    chk("bypass_b_rob", bus.issue_rob_tag, 2);
    cdb(6'd12, 32'h99);
    tick();
    idle(1'b1);
    chk("bypass_gap_valid", bus.issue_valid, 0);
    tick();
    chk("bypass_a_rob", bus.issue_rob_tag, 1);
    chk("bypass_a_src1", bus.issue_src1_val, 32'h99);
    tick();
    tick();

    // Same-cycle CDB capture at dispatch; a ready source keeps its value.
    disp(8'h03, 6'd42, 6'd3, 6'd9, 1'b1, 32'h11, 6'd9, 1'b0, 32'h0);
    cdb(6'd9, 32'h1234);
    tick();
    idle(1'b1);
    tick();
    chk("dispwake_valid", bus.issue_valid, 1);
    chk("dispwake_rob", bus.issue_rob_tag, 3);
    chk("dispwake_src2", bus.issue_src2_val, 32'h1234);
    chk("dispwake_src1", bus.issue_src1_val, 32'h11);
    tick();
    tick();

    // Fill with waiting ops, then wake slot 3 while a dispatch is refused.
    for (int i = 0; i < DEPTH; i++) begin
      disp(8'h10 + 8'(i), 6'(30 + i), 6'(i), 6'(20 + i), 1'b0, 32'h0, 6'd1, 1'b1, 32'(i));
      tick();
    end
    chk("full_occupancy", bus.occupancy, 8);
    chk("full_disp_ready", bus.disp_ready, 0);
    disp(8'hee, 6'd50, 6'd15, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
    cdb(6'd23, 32'habc);
    tick();
    idle(1'b1);
    tick();
    chk("slot3_valid", bus.issue_valid, 1);
    chk("slot3_rob", bus.issue_rob_tag, 3);
    chk("slot3_src1", bus.issue_src1_val, 32'habc);
    chk("slot3_occupancy", bus.occupancy, 7);
    chk("slot3_disp_ready", bus.disp_ready, 1);

    // ALU stall for three cycles while older entries wake.
    bus.alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cdb(6'(20 + i), 32'h100 + 32'(i));
      tick();
      chk("stall_rob", bus.issue_rob_tag, 3);
      chk("stall_occupancy", bus.occupancy, 7);
    end
    idle(1'b1);
    tick();
    chk("unstall_rob", bus.issue_rob_tag, 0);
    chk("unstall_src1", bus.issue_src1_val, 32'h100);
    chk("unstall_occupancy", bus.occupancy, 6);
    for (int i = 4; i < DEPTH; i++) begin
      cdb(6'(20 + i), 32'h200 + 32'(i));
      tick();
    end
    idle(1'b1);
    repeat (12) tick();

    // Flush with five queued, one in the issue slot and a dispatch pending.
    idle(1'b0);
    for (int i = 0; i < 6; i++) begin
      disp(8'h40, 6'd2, 6'(40 + i), 6'd1, 1'b1, 32'(i), 6'd1, 1'b1, 32'(i));
      tick();
    end
    idle(1'b0);
    chk("preflush_occupancy", bus.occupancy, 5);
    chk("preflush_issue_valid", bus.issue_valid, 1);
    disp(8'h41, 6'd3, 6'd50, 6'd1, 1'b1, 32'h5, 6'd1, 1'b1, 32'h5);
    flush = 1'b1;
    tick();
    idle(1'b1);
    chk("flush_occupancy", bus.occupancy, 0);
    chk("flush_issue_valid", bus.issue_valid, 0);
    tick();
    chk("postflush_occupancy", bus.occupancy, 0);
    chk("postflush_issue_valid", bus.issue_valid, 0);

    // Asynchronous reset in the middle of activity.
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      disp(8'h50, 6'd4, 6'(i), 6'd1, 1'b1, 32'h7, 6'd1, 1'b1, 32'h8);
      tick();
    end
    idle(1'b0);
    reset = 1'b1;
    #1;
    chk("areset_occupancy", bus.occupancy, 0);
    chk("areset_issue_valid", bus.issue_valid, 0);
    chk("areset_disp_ready", bus.disp_ready, 1);
    chk("areset_issue_rob", bus.issue_rob_tag, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      flush          = ($urandom_range(0, 79) == 0);
      bus.alu_ready  = ($urandom_range(0, 9) < 7);
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      bus.disp_op       = 8'($urandom);
      bus.disp_dst_tag  = 6'($urandom);
      bus.disp_rob_tag  = 6'($urandom);
      bus.disp_src1_tag = 6'($urandom_range(0, 15));
      bus.disp_src2_tag = 6'($urandom_range(0, 15));
      bus.disp_src1_rdy = $urandom_range(0, 1) == 1;
      bus.disp_src2_rdy = $urandom_range(0, 1) == 1;
      bus.disp_src1_val = $urandom;
      bus.disp_src2_val = $urandom;
      bus.cdb_valid  = ($urandom_range(0, 1) == 1);
      bus.cdb_tag    = 6'($urandom_range(0, 15));
      bus.cdb_value  = $urandom;
      tick();
    end
    idle(1'b1);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station and issue scheduler for the single-cycle integer ALU.
- Accepts renamed ALU ops from dispatch and holds them until both sources are ready.
- Captures operand values from the CDB and issues the oldest ready op to the ALU, at most one per cycle.
- Sits between rename/dispatch and the ALU; the ALU result returns on the CDB and wakes dependents held here.

Parameters:
- XLEN, core_pkg::XLEN (32): operand width.
- PHYS_W, core_pkg::LOG2_PREGS (6): physical tag width.
- ROB_W, 6: ROB index width.
- DEPTH, 8: queue entries.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; drop all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept
- disp_op  in  8  opcode/func, passed to ALU unchanged
- disp_dst_tag  in  PHYS_W  destination preg
- disp_rob_tag  in  ROB_W  ROB index
- disp_src1_tag / disp_src2_tag  in  PHYS_W  source pregs
- disp_src1_rdy / disp_src2_rdy  in  1  source value already valid
- disp_src1_val / disp_src2_val  in  XLEN  source value (or immediate) when rdy
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  PHYS_W  CDB preg
- cdb_value  in  XLEN  CDB data
- alu_ready  in  1  ALU accepts issue this cycle
- issue_valid  out  1  issue slot holds an op
- issue_op  out  8  op
- issue_dst_tag  out  PHYS_W  destination tag
- issue_rob_tag  out  ROB_W  ROB tag
- issue_src1_val / issue_src2_val  out  XLEN  operands
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset (async): all entry valid bits 0; issue_valid 0; all issue_* fields 0; occupancy 0. disp_ready is then 1 (combinational).
- Storage: compacting queue, slot 0 oldest. Fields per entry: valid, op, dst, rob, tag1/rdy1/val1, tag2/rdy2/val2.
- Order of update at each edge:
  1. Remove the issued entry; shift younger entries down one slot.
  2. Append the dispatched entry at the first free slot after the shift.
- disp_ready = (occupancy < DEPTH). It is not relaxed by a same-cycle issue.
- A dispatch transfer occurs when disp_valid & disp_ready.
- Dispatch wakeup: if a disp_srcN_rdy is 0 and cdb_valid & cdb_tag == disp_srcN_tag in the same cycle, store rdyN=1 and valN=cdb_value.
- Entry wakeup: for each valid entry with rdyN=0 and cdb_valid & tagN == cdb_tag, set rdyN=1 and valN=cdb_value at the edge. The entry becomes eligible in the next cycle (no same-cycle wakeup-select).
- Select: the lowest-index entry with valid & rdy1 & rdy2, decided from registered state only.
- The issue output register loads when (!issue_valid | alu_ready).
  - If it loads and a ready entry exists: capture that entry, set issue_valid=1, remove the entry.
  - If it loads and none exists: issue_valid=0.
  - If it does not load (issue_valid & !alu_ready): hold all issue_* fields; no entry is removed.
- Latency: an entry dispatched fully ready in cycle t is visible on issue_valid in cycle t+2 (t+1 it is in the queue; t+1 edge loads issue).
- A newly dispatched entry is never selected in its dispatch cycle.
- Simultaneous issue + dispatch: occupancy unchanged.
- Full queue + issue + disp_valid: disp_ready stays 0 and the dispatch is not accepted.
- flush (synchronous, priority over everything): clear all entry valid bits and issue_valid at the next edge; ignore any dispatch that cycle.
- occupancy: registered count of valid entries, updated with the queue.
- Tag 0 is not special; the CDB compare uses the full PHYS_W bits.

Decomposition:
- core_pkg gains:
  - ALU_RS_DEPTH = 8
  - typedef struct packed alu_rs_entry_t {valid, op[7:0], dst, rob, tag1, rdy1, val1, tag2, rdy2, val2}
- Sub-module alu_rs_select: combinational priority encoder over DEPTH ready bits, outputting found and index.
- Compaction and wakeup stay in the top module.

Test Plan:
- Dispatch op=0x80, both srcs rdy, vals 5/7 at t0, alu_ready=1 -> issue_valid=1 at t2 with src vals 5/7, dst/rob echoed; occupancy 1 at t1, 0 at t2.
- Dispatch A (src1 tag 12, not ready) then B (ready) -> B issues first. CDB tag 12 = 0x99 at t3 -> A issues at t5 with src1_val 0x99.
- Dispatch with src2 tag 9 not ready while CDB broadcasts tag 9 = 0x1234 in the same cycle -> entry captures 0x1234 and issues two cycles later.
- Fill 8 entries with unready sources -> disp_ready=0 and occupancy 8. Wake slot 3 -> it issues; occupancy drops to 7, disp_ready=1, older order is preserved.
- issue_valid=1 with alu_ready=0 for 3 cycles -> issue_* held constant and no entry removed; with alu_ready=1 the next oldest ready entry loads on the following edge.
- flush with 5 entries and issue_valid=1, disp_valid=1 -> next cycle occupancy 0, issue_valid 0, dispatched op absent. Async reset mid-operation gives the same result immediately.
